// File: rtl/lvds_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lvds_align_ctrl
// Brief    : Per-lane LVDS word-alignment sequencer using training-word bitslip.
// Revision : 1.0
// ============================================================================
module lvds_align_ctrl #(
  parameter int              N         = 5,
  parameter int              DW        = 8,
  parameter logic [DW-1:0]   TRAIN     = 8'hE9,
  parameter int              SETTLE    = 16,
  parameter int              MATCH     = 32,
  parameter int              MAX_SLIPS = 8
) (
  input  logic              c_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              rx_locked_i,
  input  logic [N*DW-1:0]   rxd_i,
  output logic [N-1:0]      align_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              fail_o,
  output logic [N-1:0]      lane_ok_o,
  output logic [N*4-1:0]    slip_cnt_o
);

  localparam int LW  = (N > 1) ? $clog2(N) : 1;
  localparam int SCW = $clog2(SETTLE + 1);
  localparam int MCW = $clog2(MATCH + 1);

  localparam logic [LW-1:0]  LAST_LANE  = LW'(N - 1);
  localparam logic [SCW-1:0] SETTLE_END = SCW'(SETTLE - 1);
  localparam logic [MCW-1:0] MATCH_END  = MCW'(MATCH - 1);
  localparam logic [3:0]     SLIP_LIMIT = 4'(MAX_SLIPS);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_SETTLE    = 3'd2,
    S_CHECK     = 3'd3,
    S_SLIP      = 3'd4,
    S_NEXT      = 3'd5,
    S_DONE      = 3'd6
  } state_e;

  state_e               state_q, state_d;
  logic [LW-1:0]        lane_q, lane_d;
  logic [SCW-1:0]       settle_q, settle_d;
  logic [MCW-1:0]       match_q, match_d;
  logic [N-1:0]         lane_ok_q, lane_ok_d;
  logic [N-1:0][3:0]    slip_q, slip_d;
  logic                 fail_q, fail_d;
  logic                 start_q;
  logic                 edge_q;

  logic [N-1:0][DW-1:0] lanes;
  logic [DW-1:0]        lane_word;
  logic                 accept;
  logic                 abort;

  assign lanes     = rxd_i;
  assign lane_word = lanes[lane_q];
  assign accept    = edge_q && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign abort     = !rx_locked_i && ((state_q == S_SETTLE) || (state_q == S_CHECK) ||
                                      (state_q == S_SLIP)   || (state_q == S_NEXT));

  always_ff @(posedge c_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      lane_q    <= '0;
      settle_q  <= '0;
      match_q   <= '0;
      lane_ok_q <= '0;
      slip_q    <= '0;
      fail_q    <= 1'b0;
      start_q   <= 1'b0;
      edge_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      settle_q  <= settle_d;
      match_q   <= match_d;
      lane_ok_q <= lane_ok_d;
      slip_q    <= slip_d;
      fail_q    <= fail_d;
      start_q   <= start_i;
      edge_q    <= start_i && !start_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    settle_d  = settle_q;
    match_d   = match_q;
    lane_ok_d = lane_ok_q;
    slip_d    = slip_q;
    fail_d    = fail_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d   = S_WAIT_LOCK;
          lane_d    = '0;
          settle_d  = '0;
          match_d   = '0;
          lane_ok_d = '0;
          slip_d    = '0;
          fail_d    = 1'b0;
        end
      end
      S_WAIT_LOCK: begin
        if (rx_locked_i) begin
          settle_d = '0;
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_q == SETTLE_END) begin
          match_d = '0;
          state_d = S_CHECK;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (lane_word == TRAIN) begin
          if (match_q == MATCH_END) begin
            lane_ok_d[lane_q] = 1'b1;
            state_d           = S_NEXT;
          end else begin
            match_d = match_q + 1'b1;
          end
        end else if (slip_q[lane_q] == SLIP_LIMIT) begin
          state_d = S_NEXT;
        end else begin
          state_d = S_SLIP;
        end
      end
      S_SLIP: begin
        slip_d[lane_q] = slip_q[lane_q] + 4'd1;
        settle_d       = '0;
        state_d        = S_SETTLE;
      end
      S_NEXT: begin
        if (lane_q == LAST_LANE) begin
          fail_d  = ~&lane_ok_q;
          state_d = S_DONE;
        end else begin
          lane_d   = lane_q + 1'b1;
          settle_d = '0;
          state_d  = S_SETTLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Lock loss wins over everything; a slip already pulsed this cycle still counts.
    if (abort) begin
      state_d   = S_DONE;
      fail_d    = 1'b1;
      lane_ok_d = lane_ok_q;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_align
    assign align_o[i] = (state_q == S_SLIP) && (lane_q == LW'(i));
  end

  assign busy_o     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o     = (state_q == S_DONE);
  assign fail_o     = fail_q;
  assign lane_ok_o  = lane_ok_q;
  assign slip_cnt_o = slip_q;

endmodule
`default_nettype wire

// File: tb/tb_lvds_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lvds_align_ctrl
// Brief    : Scoreboard bench for lvds_align_ctrl with a rotating-lane model.
// Revision : 1.0
// ============================================================================
module tb_lvds_align_ctrl;

  localparam int N         = 5;
  localparam int DW        = 8;
  localparam int SETTLE    = 16;
  localparam int MATCH     = 32;
  localparam int MAX_SLIPS = 8;
  localparam int CLEAN_LAT = 1 + N * (SETTLE + MATCH + 1) + 1;

  logic            c = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            rx_locked = 1'b1;
  logic [N*DW-1:0] rxd;
  logic [N-1:0]    align;
  logic            busy, done, fail;
  logic [N-1:0]    lane_ok;
  logic [N*4-1:0]  slip_cnt;

  lvds_align_ctrl #(
    .N(N), .DW(DW), .TRAIN(8'hE9), .SETTLE(SETTLE), .MATCH(MATCH), .MAX_SLIPS(MAX_SLIPS)
  ) dut (
    .c_i(c), .rst_ni(rst_n), .start_i(start), .rx_locked_i(rx_locked), .rxd_i(rxd),
    .align_o(align), .busy_o(busy), .done_o(done), .fail_o(fail),
    .lane_ok_o(lane_ok), .slip_cnt_o(slip_cnt)
  );

  always #5 c = ~c;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Lane model: output is the base word rotated left once per align pulse seen.
  logic [7:0] base [N] = '{default: 8'hE9};
  int         rot [N] = '{default: 0};
  int         pulses [N] = '{default: 0};
  int         last_pulse [N] = '{default: -1000};
  int         gap_err = 0;
  int         multi_err = 0;
  int         cyc = 0;
  logic       mon_clr = 1'b1;

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
    logic [7:0] r;
    r = v;
    for (int j = 0; j < (k % 8); j++) r = {r[6:0], r[7]};
    return r;
  endfunction

  always_comb begin
    rxd = '0;
    for (int i = 0; i < N; i++) rxd[i*DW +: DW] = rotl8(base[i], rot[i]);
  end

  always @(posedge c) begin
    cyc <= cyc + 1;
    if (mon_clr) begin
      for (int i = 0; i < N; i++) begin
        rot[i]        <= 0;
        pulses[i]     <= 0;
        last_pulse[i] <= -1000;
      end
      gap_err   <= 0;
      multi_err <= 0;
    end else begin
      if ($countones(align) > 1) multi_err <= multi_err + 1;
      for (int i = 0; i < N; i++) begin
        if (align[i]) begin
          rot[i]        <= rot[i] + 1;
          pulses[i]     <= pulses[i] + 1;
          last_pulse[i] <= cyc;
          if (cyc - last_pulse[i] < SETTLE + 1) gap_err <= gap_err + 1;
        end
      end
    end
  end

  typedef struct {
    string          name;
    logic [N-1:0]   lane_ok;
    logic           fail;
    logic [N*4-1:0] slip;
    logic [N*8-1:0] pulses;
    int             lat;
  } exp_t;

  exp_t sb[$];

  task automatic clear_monitor();
    @(negedge c) mon_clr = 1'b1;
    @(negedge c) mon_clr = 1'b0;
  endtask

  // Launches a run and checks it is accepted; returns the edge index that saw start high.
  task automatic start_run(input exp_t e, output int s);
    clear_monitor();
    sb.push_back(e);
    @(negedge c) start = 1'b0;
    @(negedge c) start = 1'b1;
    s = cyc + 1;
    @(posedge c);
    @(posedge c);
    #1;
    check_eq({e.name, "_accept_done"}, done, 1'b0);
    check_eq({e.name, "_accept_busy"}, busy, 1'b1);
  endtask

  task automatic finish_run(input int s);
    exp_t e;
    int   lat;
    bit   seen;
    logic [N*8-1:0] act_p;
    lat  = -1;
    seen = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      @(posedge c);
      #1;
      if (done) begin
        lat  = cyc - s;
        seen = 1'b1;
        break;
      end
    end
    if (sb.size() == 0) begin
      check_eq("scoreboard_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    check_eq({e.name, "_done_seen"}, seen, 1'b1);
    check_eq({e.name, "_busy"}, busy, 1'b0);
    check_eq({e.name, "_lane_ok"}, lane_ok, e.lane_ok);
    check_eq({e.name, "_fail"}, fail, e.fail);
    check_eq({e.name, "_slip_cnt"}, slip_cnt, e.slip);
    act_p = '0;
    for (int i = 0; i < N; i++) act_p[i*8 +: 8] = 8'(pulses[i]);
    check_eq({e.name, "_align_pulses"}, act_p, e.pulses);
    check_eq({e.name, "_pulse_gap"}, gap_err, 0);
    check_eq({e.name, "_onehot"}, multi_err, 0);
    if (e.lat >= 0) check_eq({e.name, "_latency"}, lat, e.lat);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   s;
    int   tot;

    repeat (2) @(posedge c);
    #1;
    check_eq("rst_align", align, '0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_fail", fail, 1'b0);
    check_eq("rst_lane_ok", lane_ok, '0);
    check_eq("rst_slip", slip_cnt, '0);
    @(negedge c) rst_n = 1'b1;

    e = '{name: "clean", lane_ok: 5'h1F, fail: 1'b0, slip: '0, pulses: '0, lat: CLEAN_LAT};
    start_run(e, s);
    finish_run(s);

    for (int i = 0; i < N; i++) base[i] = 8'hE9;
    base[2] = 8'h3D;
    e = '{name: "lane2_slip3", lane_ok: 5'h1F, fail: 1'b0, slip: 20'h00300,
          pulses: 40'h00_00_03_00_00, lat: -1};
    start_run(e, s);
    finish_run(s);

    for (int i = 0; i < N; i++) base[i] = 8'hE9;
    base[4] = 8'h00;
    e = '{name: "lane4_dead", lane_ok: 5'h0F, fail: 1'b1, slip: 20'h80000,
          pulses: 40'h08_00_00_00_00, lat: -1};
    start_run(e, s);
    finish_run(s);

    for (int i = 0; i < N; i++) base[i] = 8'hE9;
    e = '{name: "lock_drop", lane_ok: 5'h01, fail: 1'b1, slip: '0, pulses: '0, lat: -1};
    start_run(e, s);
    while (cyc < s + 79) @(negedge c);
    rx_locked = 1'b0;
    @(negedge c) rx_locked = 1'b1;
    finish_run(s);

    e = '{name: "rerun", lane_ok: 5'h1F, fail: 1'b0, slip: '0, pulses: '0, lat: CLEAN_LAT};
    start_run(e, s);
    finish_run(s);

    e = '{name: "busy_edge", lane_ok: 5'h1F, fail: 1'b0, slip: '0, pulses: '0, lat: CLEAN_LAT};
    start_run(e, s);
    while (cyc < s + 20) @(negedge c);
    start = 1'b0;
    @(negedge c) start = 1'b1;
    finish_run(s);
    repeat (20) @(negedge c);
    check_eq("held_start_done", done, 1'b1);
    check_eq("held_start_busy", busy, 1'b0);

    e = '{name: "restart", lane_ok: 5'h1F, fail: 1'b0, slip: '0, pulses: '0, lat: CLEAN_LAT};
    start_run(e, s);
    finish_run(s);

    // Async reset while a slip pulse is on the wire.
    base[4] = 8'h00;
    clear_monitor();
    @(negedge c) start = 1'b0;
    @(negedge c) start = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      @(posedge c);
      #1;
      if (align != '0) break;
    end
    check_eq("slip_reached", |align, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("arst_align", align, '0);
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_done", done, 1'b0);
    check_eq("arst_fail", fail, 1'b0);
    check_eq("arst_lane_ok", lane_ok, '0);
    check_eq("arst_slip", slip_cnt, '0);
    @(negedge c) start = 1'b0;
    @(negedge c) rst_n = 1'b1;
    clear_monitor();
    repeat (100) @(negedge c);
    tot = 0;
    for (int i = 0; i < N; i++) tot += pulses[i];
    check_eq("post_rst_pulses", tot, 0);
    check_eq("post_rst_busy", busy, 1'b0);
    check_eq("post_rst_done", done, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lvds_align_ctrl.md
Name: lvds_align_ctrl

Overview:
- Autonomous word-alignment sequencer for one imager's LVDS receiver, running in that camera's rx clock domain.
- Walks the N deserialized lanes in order and checks each against the imager training word.
- Issues single-cycle bitslip pulses to the deserializer `align` inputs until the lane matches or the slip budget runs out.
- Replaces software-driven per-lane align requests; reports per-lane lock status and slip counts for PCIe readback via the register RAM.

Parameters:
- N, 5, number of lanes (sync lane plus data lanes).
- DW, 8, bits per lane word.
- TRAIN, 8'hE9, training word expected on every lane while the imager idles.
- SETTLE, 16, cycles to wait after lock or after a slip before sampling.
- MATCH, 32, consecutive matching words required to declare a lane aligned.
- MAX_SLIPS, 8, slips attempted per lane before declaring it failed (must be ≤ 15).

Ports:
- c  in  1  rx clock; all logic is in this domain.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  level, already synchronized into c; a rising edge launches a run.
- rx_locked  in  1  deserializer PLL lock.
- rxd  in  N*DW  lane words; lane i is rxd[i*DW +: DW].
- align  out  N  one-cycle bitslip pulses; bit i drives lane i.
- busy  out  1  high from accepted start until DONE.
- done  out  1  high in DONE; cleared by the next accepted start.
- fail  out  1  valid with done; high if any lane failed or lock was lost.
- lane_ok  out  N  per-lane aligned flag, valid with done.
- slip_cnt  out  N*4  per-lane slips issued, 4 bits each at [i*4 +: 4].

Behaviour:
- Reset values: align=0, busy=0, done=0, fail=0, lane_ok=0, slip_cnt=0, state IDLE, lane index=0, all counters 0, start edge register=0.
- Start detection: rising edge of start (registered compare). An edge is accepted only in IDLE or DONE and is ignored while busy.
- On accept: clear done, fail, lane_ok and slip_cnt; set lane=0; set busy=1 on the next cycle; go to WAIT_LOCK.
- WAIT_LOCK: stay while rx_locked=0. When high, clear the settle counter and go to SETTLE. No timeout.
- SETTLE: count SETTLE cycles, then clear the match counter and go to CHECK.
- CHECK: compare lane[lane] with TRAIN each cycle.
  - Match: increment the match counter. At MATCH consecutive matches, set lane_ok[lane]=1 and go to NEXT.
  - Mismatch: go to SLIP, or to NEXT with the lane failed if slip_cnt[lane]==MAX_SLIPS.
- SLIP: assert align[lane]=1 for exactly one cycle, increment slip_cnt[lane], clear the settle counter, go to SETTLE. Exactly one align bit is high at a time; align bits for other lanes stay 0.
- NEXT: if lane==N-1, go to DONE; else increment lane and go to SETTLE. The lane counter never wraps past N-1.
- DONE: busy=0, done=1, fail = ~&lane_ok. Hold until the next accepted start.
- Loss of lock: rx_locked=0 in SETTLE, CHECK, SLIP or NEXT aborts to DONE with fail=1. lane_ok and slip_cnt keep the values reached so far. An align pulse already driven that cycle is not suppressed.
- Tie-break: abort has priority over every other transition in the same cycle.
- Latency, clean run (0 slips, rx_locked already high): per-lane cost SETTLE+MATCH+1 cycles (SETTLE, CHECK, NEXT); done rises at 1+N*(SETTLE+MATCH+1)+1 cycles after the accepted start edge.
- Async reset mid-run: immediately returns to reset values; no align pulse is emitted during or after reset.

Test Plan:
- All lanes constant 8'hE9, rx_locked=1, start 0→1 → align never pulses; done at cycle 1+5*49+1 (=247 with defaults); lane_ok=5'h1F, fail=0, slip_cnt=0.
- Lane 2 model rotates its output by one bit per align pulse and reaches 8'hE9 after 3 pulses → exactly three align[2] pulses each separated by ≥SETTLE+1 cycles; slip_cnt[11:8]=3; lane_ok=5'h1F; fail=0.
- Lane 4 held at 8'h00 → exactly 8 align[4] pulses; lane_ok=5'h0F, slip_cnt[19:16]=8, done=1, fail=1.
- rx_locked dropped for 1 cycle during lane 1 CHECK → immediate DONE, fail=1, lane_ok=5'h01; a new start edge reruns and ends with lane_ok=5'h1F.
- start edge while busy, then start held high after DONE → no restart in either case; a subsequent 0→1 restarts and clears done within 1 cycle.
- rst_n asserted during SLIP → align=0 in the same cycle (asynchronous); all outputs at reset values; no pulse after release until a new start.
